// File: rtl/aligner_add_pkg.sv
// Shared floating-point format constants and the unpacked operand type used by the add/multiply paths.
package aligner_add_pkg;

   localparam int unsigned fp_mant_width     = 23;
   localparam int unsigned fp_exp_width      = 8;
   localparam int unsigned fp_round_bits     = 3;
   localparam int          fp_min_exp        = -126;
   localparam int unsigned fp_bias           = 2 ** (fp_exp_width - 1) - 1;
   localparam int unsigned fp_ext_mant_width = 1 + fp_mant_width + fp_round_bits;
   localparam int unsigned fp_lz_width       = fp_exp_width + 2;

   // Operand after unpacking: unbiased exponent and {hidden, fraction, round bits}
   typedef struct packed {
      logic                           sign;
      logic signed [fp_exp_width+1:0] exp;
      logic [fp_ext_mant_width-1:0]   mant;
   } fp_unpacked_t;

endpackage

// File: rtl/aligner_add_lzc.sv
// Leading-zero counter; an all-zero input reports the full input width.
module lzc #(
   parameter int unsigned width     = 26,
   parameter int unsigned cnt_width = 10
) (
   input  logic [width-1:0]     data,
   output logic [cnt_width-1:0] count_c
);

   logic found;

   always_comb begin
      count_c = '0;
      found   = 1'b0;
      for (int i = int'(width) - 1; i >= 0; i--) begin
         if (!found) begin
            if (data[i]) found = 1'b1;
            else         count_c = count_c + cnt_width'(1);
         end
      end
   end

endmodule

// File: rtl/aligner_add.sv
// Two-stage floating-point add/subtract front end: operand alignment with sticky, then
// unnormalised magnitude add with leading-zero count for the normaliser downstream.
module aligner_add
   import aligner_add_pkg::*;
#(
   parameter int unsigned mant_width     = fp_mant_width,
   parameter int unsigned exp_width      = fp_exp_width,
   parameter int unsigned num_round_bits = fp_round_bits,
   parameter int signed   min_exp        = fp_min_exp
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [exp_width+mant_width:0]          op_a,
   input  logic [exp_width+mant_width:0]          op_b,
   input  logic                                   op_sub,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [mant_width+num_round_bits+1:0]   unnorm_mant,
   output logic signed [exp_width+1:0]            unnorm_exp,
   output logic [exp_width+1:0]                   lz,
   output logic                                   res_sign,
   output logic                                   special
);

   localparam int unsigned op_w  = 1 + exp_width + mant_width;
   localparam int unsigned ext_w = 1 + mant_width + num_round_bits;
   localparam int unsigned sum_w = ext_w + 1;
   localparam int unsigned e_w   = exp_width + 2;
   localparam int unsigned lz_w  = mant_width + num_round_bits;

   // Subnormals take the minimum exponent with a cleared hidden bit
   function automatic fp_unpacked_t unpack(input logic [op_w-1:0] op, input logic sgn);
      fp_unpacked_t         u;
      logic [exp_width-1:0] f;
      f      = op[op_w-2 -: exp_width];
      u.sign = sgn;
      if (f == '0) begin
         u.exp  = e_w'(min_exp);
         u.mant = {1'b0, op[mant_width-1:0], {num_round_bits{1'b0}}};
      end else begin
         u.exp  = $signed({2'b00, f}) - $signed(e_w'(fp_bias));
         u.mant = {1'b1, op[mant_width-1:0], {num_round_bits{1'b0}}};
      end
      return u;
   endfunction

   fp_unpacked_t            ua;
   fp_unpacked_t            ub;
   fp_unpacked_t            op_big;
   logic signed [e_w-1:0]   small_exp;
   logic [ext_w-1:0]        small_mant;
   logic                    a_big;
   logic [e_w-1:0]          d;
   logic [ext_w-1:0]        lost;
   logic [ext_w-1:0]        small_sh;
   logic                    eff_sub;
   logic                    in_special;

   logic                    s1_valid;
   logic [ext_w-1:0]        s1_big;
   logic [ext_w-1:0]        s1_small;
   logic signed [e_w-1:0]   s1_exp;
   logic                    s1_sign;
   logic                    s1_sub;
   logic                    s1_special;

   logic [sum_w-1:0]        sum;
   logic                    sum_zero;
   logic [fp_lz_width-1:0]  sum_lz;
   logic                    s2_load;

   // Stage 1 datapath: unpack, order by magnitude, align the smaller operand
   always_comb begin
      ua         = unpack(op_a, op_a[op_w-1]);
      ub         = unpack(op_b, op_b[op_w-1] ^ op_sub);
      eff_sub    = ua.sign ^ ub.sign;
      in_special = (&op_a[op_w-2 -: exp_width]) | (&op_b[op_w-2 -: exp_width]);
      a_big      = (ua.exp > ub.exp) || ((ua.exp == ub.exp) && (ua.mant >= ub.mant));
      op_big     = a_big ? ua : ub;
      small_exp  = a_big ? ub.exp : ua.exp;
      small_mant = a_big ? ub.mant : ua.mant;
      d          = e_w'(op_big.exp - small_exp);
      // Bits pushed past the LSB collapse into a sticky bit; a full shift-out keeps only the OR
      lost       = small_mant & ~({ext_w{1'b1}} << d);
      small_sh   = (small_mant >> d) | ext_w'(|lost);
   end

   // Stage 2 datapath: magnitude add/subtract; ordering guarantees a non-negative difference
   always_comb begin
      sum      = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});
      sum_zero = (sum == '0);
   end

   lzc #(
      .width     (lz_w),
      .cnt_width (fp_lz_width)
   ) u_lzc (
      .data    (sum[lz_w-1:0]),
      .count_c (sum_lz)
   );

   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;

   // Pipeline registers; reset discards anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_big      <= '0;
         s1_small    <= '0;
         s1_exp      <= '0;
         s1_sign     <= 1'b0;
         s1_sub      <= 1'b0;
         s1_special  <= 1'b0;
         out_valid   <= 1'b0;
         unnorm_mant <= '0;
         unnorm_exp  <= '0;
         lz          <= '0;
         res_sign    <= 1'b0;
         special     <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_big     <= op_big.mant;
               s1_small   <= small_sh;
               s1_exp     <= op_big.exp;
               s1_sign    <= op_big.sign;
               s1_sub     <= eff_sub;
               s1_special <= in_special;
            end
         end
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               unnorm_mant <= sum;
               unnorm_exp  <= s1_exp;
               lz          <= e_w'(sum_lz);
               res_sign    <= sum_zero ? 1'b0 : s1_sign;
               special     <= s1_special;
            end
         end
      end
   end

endmodule

// File: tb/tb_aligner_add.sv
// Directed self-checking bench for aligner_add at binary32 defaults.
module tb_aligner_add;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        op_a;
   logic [31:0]        op_b;
   logic               op_sub;
   logic               out_valid;
   logic               out_ready;
   logic [27:0]        unnorm_mant;
   logic signed [9:0]  unnorm_exp;
   logic [9:0]         lz;
   logic               res_sign;
   logic               special;

   int n_pass;
   int n_total;

   aligner_add dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_sub      (op_sub),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .unnorm_mant (unnorm_mant),
      .unnorm_exp  (unnorm_exp),
      .lz          (lz),
      .res_sign    (res_sign),
      .special     (special)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Present one operand pair and hold it until accepted (bounded)
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int n;
      @(negedge clk);
      op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (n >= 20) $display("FAIL send_accept: in_ready stayed %b want 1", in_ready);
      else         n_pass++;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Called just after the accepting edge; returns edges from accept until out_valid is seen
   task automatic wait_out(output int cyc);
      cyc = 1;
      @(negedge clk);
      while (!out_valid && cyc < 10) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
      else n_pass++;
      n_total++;
      if (unnorm_mant !== 28'h0 || lz !== 10'd0 || special !== 1'b0 || res_sign !== 1'b0)
         $display("FAIL rst_outputs: mant %h lz %0d special %b sign %b want all 0",
                  unnorm_mant, lz, special, res_sign);
      else n_pass++;
   endtask

   task automatic test_add();
      int lat;
      send(32'h3F800000, 32'h3F800000, 1'b0);
      wait_out(lat);
      n_total++;
      if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat);
      else n_pass++;
      n_total++;
      if (unnorm_mant !== 28'h8000000) $display("FAIL add_mant: got %h want 8000000", unnorm_mant);
      else n_pass++;
      n_total++;
      if (unnorm_exp !== 10'sd0 || res_sign !== 1'b0 || special !== 1'b0)
         $display("FAIL add_exp_sign: exp %0d sign %b special %b want 0 0 0", unnorm_exp, res_sign, special);
      else n_pass++;
      n_total++;
      if (lz !== 10'd26) $display("FAIL add_lz: got %0d want 26", lz);
      else n_pass++;
   endtask

   task automatic test_sub_zero();
      int lat;
      send(32'h3F800000, 32'h3F800000, 1'b1);
      wait_out(lat);
      n_total++;
      if (unnorm_mant !== 28'h0) $display("FAIL subz_mant: got %h want 0", unnorm_mant);
      else n_pass++;
      n_total++;
      if (res_sign !== 1'b0 || unnorm_exp !== 10'sd0)
         $display("FAIL subz_sign_exp: sign %b exp %0d want 0 0", res_sign, unnorm_exp);
      else n_pass++;
      n_total++;
      if (lz !== 10'd26) $display("FAIL subz_lz: got %0d want 26", lz);
      else n_pass++;
   endtask

   task automatic test_sub_half();
      int lat;
      send(32'h3FC00000, 32'h3F800000, 1'b1);
      wait_out(lat);
      n_total++;
      if (unnorm_mant !== 28'h2000000) $display("FAIL subh_mant: got %h want 2000000", unnorm_mant);
      else n_pass++;
      n_total++;
      if (unnorm_exp !== 10'sd0 || lz !== 10'd0 || res_sign !== 1'b0)
         $display("FAIL subh_exp_lz: exp %0d lz %0d sign %b want 0 0 0", unnorm_exp, lz, res_sign);
      else n_pass++;
   endtask

   task automatic test_sticky_far();
      int lat;
      send(32'h3F800000, 32'h30800000, 1'b0);
      wait_out(lat);
      n_total++;
      if (unnorm_mant !== 28'h4000001) $display("FAIL far_mant: got %h want 4000001", unnorm_mant);
      else n_pass++;
      n_total++;
      if (unnorm_exp !== 10'sd0) $display("FAIL far_exp: got %0d want 0", unnorm_exp);
      else n_pass++;
   endtask

   // d = 4: the small operand's fraction LSB lands in the shifted-out bits
   task automatic test_sticky_near();
      int lat;
      send(32'h3F800000, 32'h3D800001, 1'b0);
      wait_out(lat);
      n_total++;
      if (unnorm_mant !== 28'h4400001) $display("FAIL near_mant: got %h want 4400001", unnorm_mant);
      else n_pass++;
      n_total++;
      if (lz !== 10'd3) $display("FAIL near_lz: got %0d want 3", lz);
      else n_pass++;
   endtask

   // 1.0 - 2.0: b is larger, so its effective (negated) sign wins
   task automatic test_sub_negative();
      int lat;
      send(32'h3F800000, 32'h40000000, 1'b1);
      wait_out(lat);
      n_total++;
      if (unnorm_mant !== 28'h2000000) $display("FAIL neg_mant: got %h want 2000000", unnorm_mant);
      else n_pass++;
      n_total++;
      if (unnorm_exp !== 10'sd1 || res_sign !== 1'b1)
         $display("FAIL neg_exp_sign: exp %0d sign %b want 1 1", unnorm_exp, res_sign);
      else n_pass++;
   endtask

   task automatic test_special();
      int lat;
      send(32'h7F800000, 32'h3F800000, 1'b0);
      wait_out(lat);
      n_total++;
      if (special !== 1'b1) $display("FAIL special_inf: got %b want 1", special);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [27:0] cap_mant;
      logic [9:0]  cap_lz;
      logic [27:0] got[3];
      int          ng;
      int          n;
      @(negedge clk);
      out_ready = 1'b0;
      op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 op_a = 32'h3FC00000; op_b = 32'h3F800000; op_sub = 1'b1;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready_first: got %b want 1", in_ready);
      else n_pass++;
      @(posedge clk);
      #1 op_a = 32'h3F800000; op_b = 32'h3D800001; op_sub = 1'b0;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL b2b_stall: in_ready %b out_valid %b want 0 1", in_ready, out_valid);
      else n_pass++;
      cap_mant = unnorm_mant;
      cap_lz   = lz;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_total++;
         if (unnorm_mant !== cap_mant || lz !== cap_lz || out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL b2b_hold: mant %h lz %0d valid %b ready %b want %h %0d 1 0",
                     unnorm_mant, lz, out_valid, in_ready, cap_mant, cap_lz);
         else n_pass++;
      end
      out_ready = 1'b1;
      got[0] = unnorm_mant;
      ng = 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (ng < 3 && n < 10) begin
         @(negedge clk);
         if (out_valid) begin
            got[ng] = unnorm_mant;
            ng++;
         end
         @(posedge clk);
         n++;
      end
      n_total++;
      if (ng !== 3) $display("FAIL b2b_count: got %0d results want 3", ng);
      else n_pass++;
      n_total++;
      if (got[0] !== 28'h8000000) $display("FAIL b2b_res0: got %h want 8000000", got[0]);
      else n_pass++;
      n_total++;
      if (got[1] !== 28'h2000000) $display("FAIL b2b_res1: got %h want 2000000", got[1]);
      else n_pass++;
      n_total++;
      if (got[2] !== 28'h4400001) $display("FAIL b2b_res2: got %h want 4400001", got[2]);
      else n_pass++;
   endtask

   task automatic test_reset_flush();
      logic saw;
      @(negedge clk);
      out_ready = 1'b0;
      op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 op_a = 32'h3FC00000; op_b = 32'h3F800000; op_sub = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL flush_full: out_valid %b in_ready %b want 1 0", out_valid, in_ready);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flush_async: out_valid %b want 0", out_valid);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready);
      else n_pass++;
      saw = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      n_total++;
      if (saw !== 1'b0) $display("FAIL flush_stale: out_valid seen %b want 0", saw);
      else n_pass++;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_sub    = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_add();
      test_sub_zero();
      test_sub_half();
      test_sticky_far();
      test_sticky_near();
      test_sub_negative();
      test_special();
      test_back_to_back();
      test_reset_flush();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
